cnn_layer_1_ctrl: RTL and testbench
===================================

// Module: cnn_layer_1_ctrl
// PURPOSE
//  Sequencer for the layer-1 convolution datapath (padding + per-channel MAC array). On start it
//  captures the feature map, walks every output position in raster order, issues one window
//  origin per enabled cycle, and tracks in-flight MAC results through MAC_LATENCY stages. It
//  presents results on a valid/ready port with backpressure that freezes the whole datapath.
// PARAMETERS
//  IMAGE_WIDTH   28  input feature-map width (pixels)
//  IMAGE_HEIGHT  28  input feature-map height (pixels)
//  KERNEL_SIZE   3   square kernel edge; stride fixed at 1
//  PAD           1   zero-padding on each side
//  MAC_LATENCY   4   datapath cycles from mac_issue to result (>=1), counted in enabled cycles
//  Derived: OUT_W = IMAGE_WIDTH+2*PAD-KERNEL_SIZE+1, OUT_H likewise; CW=$clog2(OUT_W), RW=$clog2(OUT_H)
// PORTS
//  clk            in   1   clock, all logic on rising edge
//  reset          in   1   synchronous, active-high reset
//  start          in   1   data_valid from upstream; feature_map valid this cycle
//  abort          in   1   synchronous flush of current frame
//  busy           out  1   high from start acceptance until done pulse (inclusive)
//  feature_latch  out  1   one-cycle pulse: datapath captures feature_map
//  mac_en         out  1   global datapath pipeline enable (low = freeze)
//  mac_issue      out  1   a new window enters the datapath this cycle
//  win_row        out  RW  window origin row in padded coordinates
//  win_col        out  CW  window origin column in padded coordinates
//  result_valid   out  1   result at datapath output valid
//  result_ready   in   1   downstream accepts result
//  result_row     out  RW  output row of presented result
//  result_col     out  CW  output column of presented result
//  result_last    out  1   presented result is (OUT_H-1, OUT_W-1)
//  done           out  1   one-cycle pulse after last result accepted
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except mac_en=1; tracking pipeline cleared.
//  FSM: IDLE -> RUN (start&&IDLE) -> DRAIN (last window issued) -> DONE (last result accepted)
//   -> IDLE (next cycle, unconditional). start outside IDLE is ignored, never queued.
//  Start: start sampled in IDLE at edge t -> feature_latch=1, busy=1, state RUN during cycle t+1.
//  mac_en = !(result_valid && !result_ready), combinational. mac_en=0 freezes row/col counters,
//   tracking shift register and result outputs; result_* stay stable while valid&&!ready.
//  RUN: mac_issue = mac_en; win_row/col start at (0,0), col increments per issue, wraps at
//   OUT_W-1 to 0 with row+1. Issue of (OUT_H-1,OUT_W-1) moves to DRAIN; no issue in DRAIN.
//  Tracking: MAC_LATENCY-deep shift register of {valid,row,col,last}, shifts when mac_en=1;
//   its tail drives result_*. First result visible exactly MAC_LATENCY enabled cycles after issue.
//  Ordering: results strictly raster order; exactly OUT_W*OUT_H results per frame, none dropped or
//   duplicated under any ready pattern.
//  Transfer = result_valid && result_ready. Transfer with result_last -> DONE; done=1 one cycle.
//  abort (any state except IDLE): next cycle IDLE, pipeline valids cleared, result_valid=0, no
//   done pulse. abort has priority over start and over a simultaneous last transfer.
//  reset mid-frame: identical to abort plus counters to 0; reset wins over abort and start.
//  win_* and result_* hold last value when not qualified; only valid/issue bits are meaningful.
//  Counters sized exactly RW/CW bits; wrap compare uses OUT_W-1 / OUT_H-1, never overflow.
// TESTING
//  1 Defaults, start at t, result_ready=1: feature_latch at t+1; first result (0,0) at t+5;
//    784 results raster order; result_last (27,27) at t+788; done at t+789; busy low at t+790.
//  2 result_ready toggling 1,0,0 pattern: still 784 results, in order, no dup; result_* stable
//    during stall; mac_issue never high while mac_en=0.
//  3 start pulses while busy (t+10, t+400): ignored; frame count and outputs identical to test 1.
//  4 abort at t+300 with results in flight: next cycle busy=0, result_valid=0, no done; new start
//    at t+305 yields full clean 784-result frame starting (0,0).
//  5 reset asserted mid-DRAIN with result_ready=0: all outputs at reset values next cycle.
//  6 IMAGE 5x5, PAD 0, KERNEL 3, MAC_LATENCY 1: 9 results, wrap at col 2, last (2,2), done after.

Source files
------------

// File: rtl/cnn_layer_1_ctrl.sv
// ----------------------------------------------------------------------------
// cnn_layer_1_ctrl
//
// Sequencer for the layer-1 convolution datapath (zero padding followed by a
// per-channel MAC array). On an accepted start it pulses feature_latch. It then
// walks every output position in raster order and issues one window origin per
// enabled cycle. A MAC_LATENCY-deep tag pipeline follows the windows through
// the datapath, and its tail drives the result port. Backpressure on the
// result port drops mac_en, which freezes the whole datapath and this
// controller together.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   start             feature map valid; accepted only while idle
//   abort             flushes the current frame (ignored while idle)
//   busy              high from the cycle after start acceptance up to and
//                     including the done cycle
//   feature_latch     one-cycle capture strobe for the feature map
//   mac_en            global datapath enable (low = freeze)
//   mac_issue         a window enters the datapath this cycle
//   win_row/win_col   window origin in padded coordinates
//   result_valid/ready/row/col/last   result handshake and tag
//   done              one-cycle pulse after the last result is accepted
// ----------------------------------------------------------------------------
module cnn_layer_1_ctrl #(
    parameter int  IMAGE_WIDTH  = 28,
    parameter int  IMAGE_HEIGHT = 28,
    parameter int  KERNEL_SIZE  = 3,
    parameter int  PAD          = 1,
    parameter int  MAC_LATENCY  = 4,
    localparam int OUT_W = IMAGE_WIDTH  + 2 * PAD - KERNEL_SIZE + 1,
    localparam int OUT_H = IMAGE_HEIGHT + 2 * PAD - KERNEL_SIZE + 1,
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          feature_latch,
    output logic          mac_en,
    output logic          mac_issue,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [RW-1:0] result_row,
    output logic [CW-1:0] result_col,
    output logic          result_last,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int            TAIL    = MAC_LATENCY - 1;
    localparam logic [CW-1:0] COL_MAX = CW'(OUT_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(OUT_H - 1);
    localparam logic [CW-1:0] COL_ONE = CW'(1);
    localparam logic [RW-1:0] ROW_ONE = RW'(1);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [RW-1:0]          row_r;
    logic [CW-1:0]          col_r;
    logic                   feature_latch_r;
    logic [MAC_LATENCY-1:0] pipe_vld_r;
    logic [MAC_LATENCY-1:0] pipe_last_r;
    logic [RW-1:0]          pipe_row_r [MAC_LATENCY];
    logic [CW-1:0]          pipe_col_r [MAC_LATENCY];

    logic mac_en_s;
    logic issue_s;
    logic start_acc_s;
    logic flush_s;
    logic last_win_s;
    logic last_xfer_s;

    // Enable, issue and frame-event decode shared by the FSM and datapath.
    always_comb begin
        mac_en_s    = !(pipe_vld_r[TAIL] && !result_ready);
        issue_s     = 1'b0;
        start_acc_s = 1'b0;
        flush_s     = abort && (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE:  start_acc_s = start && !abort;
            ST_RUN:   issue_s     = mac_en_s;
            ST_DRAIN: issue_s     = 1'b0;
            ST_DONE:  issue_s     = 1'b0;
            default:  issue_s     = 1'b0;
        endcase
        last_win_s  = issue_s && (row_r == ROW_MAX) && (col_r == COL_MAX);
        last_xfer_s = pipe_vld_r[TAIL] && result_ready && pipe_last_r[TAIL];
    end

    // State register and the one-cycle capture strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            feature_latch_r <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            feature_latch_r <= start_acc_s;
        end
    end

    // Next-state logic; abort wins over start and over a final transfer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) state_nxt_s = ST_RUN;
                else             state_nxt_s = ST_IDLE;
            end
            ST_RUN: begin
                if (flush_s)          state_nxt_s = ST_IDLE;
                else if (last_xfer_s) state_nxt_s = ST_DONE;
                else if (last_win_s)  state_nxt_s = ST_DRAIN;
                else                  state_nxt_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (flush_s)          state_nxt_s = ST_IDLE;
                else if (last_xfer_s) state_nxt_s = ST_DONE;
                else                  state_nxt_s = ST_DRAIN;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode from state, counters and the pipeline tail.
    always_comb begin
        busy          = (state_r != ST_IDLE);
        done          = (state_r == ST_DONE);
        feature_latch = feature_latch_r;
        mac_en        = mac_en_s;
        mac_issue     = issue_s;
        win_row       = row_r;
        win_col       = col_r;
        result_valid  = pipe_vld_r[TAIL];
        result_row    = pipe_row_r[TAIL];
        result_col    = pipe_col_r[TAIL];
        result_last   = pipe_last_r[TAIL];
    end

    // Raster window counters; cleared on each new frame so that an aborted
    // frame leaves no residue.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_r <= {RW{1'b0}};
            col_r <= {CW{1'b0}};
        end else if (start_acc_s) begin
            row_r <= {RW{1'b0}};
            col_r <= {CW{1'b0}};
        end else if (issue_s && !flush_s) begin
            if (col_r == COL_MAX) begin
                col_r <= {CW{1'b0}};
                if (row_r == ROW_MAX) row_r <= {RW{1'b0}};
                else                  row_r <= row_r + ROW_ONE;
            end else begin
                col_r <= col_r + COL_ONE;
            end
        end else begin
            row_r <= row_r;
            col_r <= col_r;
        end
    end

    // Tag pipeline that mirrors the MAC datapath. It moves only while the
    // datapath is enabled, so a stalled result stays stable at the tail.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_vld_r  <= {MAC_LATENCY{1'b0}};
            pipe_last_r <= {MAC_LATENCY{1'b0}};
            for (int i = 0; i < MAC_LATENCY; i++) begin
                pipe_row_r[i] <= {RW{1'b0}};
                pipe_col_r[i] <= {CW{1'b0}};
            end
        end else if (flush_s) begin
            pipe_vld_r <= {MAC_LATENCY{1'b0}};
        end else if (mac_en_s) begin
            for (int i = MAC_LATENCY - 1; i > 0; i--) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_last_r[i] <= pipe_last_r[i-1];
                pipe_row_r[i]  <= pipe_row_r[i-1];
                pipe_col_r[i]  <= pipe_col_r[i-1];
            end
            pipe_vld_r[0]  <= issue_s;
            pipe_last_r[0] <= last_win_s;
            pipe_row_r[0]  <= row_r;
            pipe_col_r[0]  <= col_r;
        end else begin
            pipe_vld_r <= pipe_vld_r;
        end
    end

endmodule

// File: tb/tb_cnn_layer_1_ctrl.sv
// Bench for cnn_layer_1_ctrl: a 28x28/pad1/latency4 instance (dut 0) and a
// 5x5/pad0/latency1 instance (dut 1), checked every cycle against a frame-level
// model (window and result indices, busy/latch/done expectations) plus literal
// timing expectations per scenario.
module tb_cnn_layer_1_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start_a, abort_a, ready_a;
    logic       busy_a, fl_a, en_a, iss_a, rv_a, last_a, done_a;
    logic [4:0] wr_a, wc_a, rrow_a, rcol_a;
    logic       start_b, abort_b, ready_b;
    logic       busy_b, fl_b, en_b, iss_b, rv_b, last_b, done_b;
    logic [1:0] wr_b, wc_b, rrow_b, rcol_b;

    cnn_layer_1_ctrl dut_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .busy(busy_a), .feature_latch(fl_a), .mac_en(en_a), .mac_issue(iss_a),
        .win_row(wr_a), .win_col(wc_a), .result_valid(rv_a), .result_ready(ready_a),
        .result_row(rrow_a), .result_col(rcol_a), .result_last(last_a), .done(done_a)
    );

    cnn_layer_1_ctrl #(
        .IMAGE_WIDTH(5), .IMAGE_HEIGHT(5), .KERNEL_SIZE(3), .PAD(0), .MAC_LATENCY(1)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .busy(busy_b), .feature_latch(fl_b), .mac_en(en_b), .mac_issue(iss_b),
        .win_row(wr_b), .win_col(wc_b), .result_valid(rv_b), .result_ready(ready_b),
        .result_row(rrow_b), .result_col(rcol_b), .result_last(last_b), .done(done_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // frame model state, indexed by dut
    int m_busy[2], m_fl[2], m_done[2], m_kill[2], m_stall[2], m_pbsy[2];
    int m_iss[2], m_res[2], m_prow[2], m_pcol[2], m_plast[2];
    int fl_cyc[2], first_cyc[2], last_cyc[2], done_cyc[2], idle_cyc[2], done_cnt[2];
    int r3_row[2], r3_col[2];

    task automatic chk(input int d, input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL dut%0d %s: got %0d expected %0d (cycle %0d)", d, nm, act, exp, cyc);
        end
    endtask

    task automatic check_dut(input int d, input int ow, input int oh,
                             input logic rv, input logic rr, input int rrow, input int rcol,
                             input logic rlast, input logic iss, input int wr, input int wc,
                             input logic en, input logic bsy, input logic fl, input logic dn,
                             input logic st, input logic ab, input logic rs);
        int n;
        int cur_done;
        int nxt_done;
        n        = ow * oh;
        cur_done = m_done[d];
        nxt_done = 0;
        chk(d, "mac_en", en, (rv && !rr) ? 0 : 1);
        chk(d, "busy", bsy, m_busy[d]);
        chk(d, "feature_latch", fl, m_fl[d]);
        chk(d, "done", dn, cur_done);
        if (m_kill[d] != 0 || m_busy[d] == 0) chk(d, "valid_when_idle", rv, 0);
        if (m_busy[d] == 0) chk(d, "issue_when_idle", iss, 0);
        if (m_stall[d] != 0) begin
            chk(d, "stall_valid", rv, 1);
            chk(d, "stall_row", rrow, m_prow[d]);
            chk(d, "stall_col", rcol, m_pcol[d]);
            chk(d, "stall_last", rlast, m_plast[d]);
        end
        if (iss) begin
            chk(d, "issue_while_enabled", en, 1);
            chk(d, "issue_count_in_range", (m_iss[d] < n) ? 1 : 0, 1);
            chk(d, "win_row", wr, m_iss[d] / ow);
            chk(d, "win_col", wc, m_iss[d] % ow);
            m_iss[d]++;
        end
        if (rv && rr) begin
            chk(d, "result_row", rrow, m_res[d] / ow);
            chk(d, "result_col", rcol, m_res[d] % ow);
            chk(d, "result_last", rlast, (m_res[d] == n - 1) ? 1 : 0);
            if (m_res[d] == 0) first_cyc[d] = cyc;
            if (m_res[d] == 3) begin
                r3_row[d] = rrow;
                r3_col[d] = rcol;
            end
            if (m_res[d] == n - 1) begin
                last_cyc[d] = cyc;
                nxt_done = (m_busy[d] != 0 && !ab && !rs) ? 1 : 0;
            end
            m_res[d]++;
        end
        if (fl) fl_cyc[d] = cyc;
        if (dn) begin
            done_cyc[d] = cyc;
            done_cnt[d]++;
            chk(d, "results_at_done", m_res[d], n);
        end
        if (m_pbsy[d] != 0 && !bsy) idle_cyc[d] = cyc;
        m_pbsy[d]  = bsy;
        m_stall[d] = (rv && !rr && !rs && !(ab && m_busy[d] != 0)) ? 1 : 0;
        m_prow[d]  = rrow;
        m_pcol[d]  = rcol;
        m_plast[d] = rlast;
        m_kill[d]  = (rs || (ab && m_busy[d] != 0)) ? 1 : 0;
        m_fl[d]    = 0;
        m_done[d]  = nxt_done;
        if (rs) begin
            m_busy[d] = 0;
            m_done[d] = 0;
        end else if (m_busy[d] != 0) begin
            if (ab || cur_done != 0) m_busy[d] = 0;
        end else if (st && !ab) begin
            m_busy[d] = 1;
            m_fl[d]   = 1;
            m_iss[d]  = 0;
            m_res[d]  = 0;
        end
    endtask

    // single compare process, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            check_dut(0, 28, 28, rv_a, ready_a, rrow_a, rcol_a, last_a, iss_a, wr_a, wc_a,
                      en_a, busy_a, fl_a, done_a, start_a, abort_a, reset);
            check_dut(1, 3, 3, rv_b, ready_b, rrow_b, rcol_b, last_b, iss_b, wr_b, wc_b,
                      en_b, busy_b, fl_b, done_b, start_b, abort_b, reset);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: stray starts
    task automatic run_frame(input int d, input int mode, input int abort_at, output int ts);
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        tick();
        ts = cyc - 1;
        if (d == 0) start_a = 1'b0; else start_b = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if (idle_cyc[d] > ts + 1) break;
            if (d == 0) begin
                ready_a = (mode == 1) ? (((cyc - ts) % 3) == 1) : 1'b1;
                start_a = (mode == 2) && (cyc == ts + 10 || cyc == ts + 400);
                abort_a = (abort_at > 0) && (cyc == ts + abort_at);
            end else begin
                ready_b = 1'b1;
            end
            tick();
        end
        chk(d, "frame_finished_in_budget", (idle_cyc[d] > ts + 1) ? 1 : 0, 1);
        start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
    endtask

    initial begin
        int ts;
        int dc;
        reset = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
        start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk_on = 1'b1;

        // reset state
        chk(0, "rst_busy", busy_a, 0);
        chk(0, "rst_feature_latch", fl_a, 0);
        chk(0, "rst_mac_en", en_a, 1);
        chk(0, "rst_mac_issue", iss_a, 0);
        chk(0, "rst_result_valid", rv_a, 0);
        chk(0, "rst_done", done_a, 0);
        chk(0, "rst_win", {wr_a, wc_a}, 0);
        tick();

        // 1: plain frame, ready always high
        run_frame(0, 0, 0, ts);
        chk(0, "t1_latch_time", fl_cyc[0] - ts, 1);
        chk(0, "t1_first_result_time", first_cyc[0] - ts, 5);
        chk(0, "t1_last_result_time", last_cyc[0] - ts, 788);
        chk(0, "t1_done_time", done_cyc[0] - ts, 789);
        chk(0, "t1_busy_low_time", idle_cyc[0] - ts, 790);
        chk(0, "t1_result_count", m_res[0], 784);
        chk(0, "t1_third_result_col", r3_col[0], 3);
        repeat (2) tick();

        // 2: ready pattern 1,0,0
        dc = done_cnt[0];
        run_frame(0, 1, 0, ts);
        chk(0, "t2_result_count", m_res[0], 784);
        chk(0, "t2_one_done", done_cnt[0] - dc, 1);
        repeat (2) tick();

        // 3: stray starts while busy are ignored
        dc = done_cnt[0];
        run_frame(0, 2, 0, ts);
        chk(0, "t3_first_result_time", first_cyc[0] - ts, 5);
        chk(0, "t3_done_time", done_cyc[0] - ts, 789);
        chk(0, "t3_result_count", m_res[0], 784);
        chk(0, "t3_one_done", done_cnt[0] - dc, 1);
        repeat (2) tick();

        // 4: abort with results in flight, then a clean frame
        dc = done_cnt[0];
        run_frame(0, 0, 300, ts);
        chk(0, "t4_busy_low_after_abort", idle_cyc[0] - ts, 301);
        chk(0, "t4_no_done", done_cnt[0] - dc, 0);
        chk(0, "t4_partial", (m_res[0] > 0 && m_res[0] < 784) ? 1 : 0, 1);
        while (cyc < ts + 305) tick();
        run_frame(0, 0, 0, ts);
        chk(0, "t4_restart_first_time", first_cyc[0] - ts, 5);
        chk(0, "t4_restart_count", m_res[0], 784);
        chk(0, "t4_restart_done", done_cnt[0] - dc, 1);
        repeat (2) tick();

        // 5: reset in DRAIN while stalled
        start_a = 1'b1;
        tick();
        ts = cyc - 1;
        start_a = 1'b0;
        while (cyc < ts + 786) tick();
        ready_a = 1'b0;
        tick();
        tick();
        chk(0, "t5_stalled_valid", rv_a, 1);
        chk(0, "t5_stalled_busy", busy_a, 1);
        chk(0, "t5_stalled_mac_en", en_a, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk(0, "t5_busy", busy_a, 0);
        chk(0, "t5_feature_latch", fl_a, 0);
        chk(0, "t5_mac_en", en_a, 1);
        chk(0, "t5_mac_issue", iss_a, 0);
        chk(0, "t5_result_valid", rv_a, 0);
        chk(0, "t5_result_tag", {rrow_a, rcol_a, last_a}, 0);
        chk(0, "t5_win", {wr_a, wc_a}, 0);
        chk(0, "t5_done", done_a, 0);
        ready_a = 1'b1;
        repeat (2) tick();

        // 6: 5x5 image, no padding, latency 1
        dc = done_cnt[1];
        run_frame(1, 0, 0, ts);
        chk(1, "t6_first_result_time", first_cyc[1] - ts, 2);
        chk(1, "t6_last_result_time", last_cyc[1] - ts, 10);
        chk(1, "t6_done_time", done_cyc[1] - ts, 11);
        chk(1, "t6_result_count", m_res[1], 9);
        chk(1, "t6_wrap_row", r3_row[1], 1);
        chk(1, "t6_wrap_col", r3_col[1], 0);
        chk(1, "t6_one_done", done_cnt[1] - dc, 1);
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
